afifo_rd_streamer: RTL and testbench
====================================

Name: afifo_rd_streamer

Overview:
- Read-side consumer of the async FIFO; lives entirely in the read clock domain.
- Drains words with first-word-fall-through semantics: rdata is valid whenever rempty=0, and rinc pops the word.
- Re-presents the words on a valid/ready stream through a 2-entry buffer, adding burst framing (m_last) and a delivered-word counter.
- Complements the write-side producer so a bench can close the loop from winc to m_valid.

Parameters:
- DATA_W, 8, width of rdata and m_data.
- BURST_LEN, 4, beats per burst; m_last marks beat BURST_LEN-1. Legal range 1..256.
- CNT_W, 16, width of the words_out counter.

Ports:
- rclk  in  1  read-domain clock. Single clock; every register is on its rising edge.
- rrst_n  in  1  reset, synchronous, active-low.
- en  in  1  enable new FIFO pops; does not affect draining of already-buffered words.
- rempty  in  1  FIFO empty flag.
- rdata  in  DATA_W  FIFO head word; valid when rempty=0.
- rinc  out  1  FIFO pop strobe.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  output word.
- m_last  out  1  last beat of burst.
- words_out  out  CNT_W  count of accepted output beats (saturating).
- busy  out  1  buffer non-empty, or a pop is being issued this cycle.

Behaviour:
- Reset values, taken on the first rclk edge with rrst_n=0:
  - occ=0, head/tail pointers=0, beat=0, words_out=0.
  - m_valid=0, m_last=0, m_data=0 (buffer entries cleared).
  - rinc is gated with rrst_n, so it is 0 in any cycle where rrst_n=0.
- Reset mid-transfer: buffered words are discarded, not delivered. The FIFO word whose rinc was suppressed remains in the FIFO.
- Pop rule: rinc = rrst_n & en & ~rempty & (occ<2).
  - Depends only on registered occ; no combinational path from m_ready to rinc.
- Push: when rinc=1, rdata is written at the tail on that same edge. rdata is sampled in the same cycle rinc is asserted.
- Output:
  - m_valid = (occ!=0); m_data = entry at head.
  - Registered, so stable while m_valid=1 and m_ready=0.
- Handshake:
  - A transfer occurs on an edge where m_valid & m_ready.
  - The head pointer advances on a transfer.
  - m_valid never drops without a transfer, except via reset.
- Occupancy update:
  - occ += push - pop.
  - Simultaneous push and pop: occ unchanged.
  - occ==2: no push. occ==0: no pop possible.
- Latency and throughput:
  - A word appears on m_data 1 cycle after its rinc cycle.
  - With rempty=0, en=1 and m_ready held 1, throughput is 1 word/cycle sustained, with occ steady at 1.
- Backpressure: with m_ready=0, at most 2 pops occur, then rinc stays 0 until a transfer frees space.
- Burst framing:
  - beat increments on each transfer and wraps to 0 after BURST_LEN-1.
  - m_last = m_valid & (beat==BURST_LEN-1).
  - BURST_LEN=1: m_last=1 on every valid beat.
  - en and rempty do not reset beat; bursts span FIFO gaps.
- Counter: words_out increments on each transfer and saturates at 2^CNT_W-1 (no wrap).
- en deassert: pops stop from that cycle; up to 2 buffered words still drain. Re-assert resumes pops next cycle.
- rempty asserting while occ>0: buffered words still deliver; no underflow (rinc is gated by rempty).

Test Plan:
- Reset, then FIFO preloaded 0x11,0x22,0x33,0x44, en=1, m_ready=1 -> rinc high 4 consecutive cycles. m_data=0x11..0x44 on consecutive cycles starting 1 cycle after first rinc. m_last only on 0x44. words_out=4. busy drops after last transfer.
- 6 words queued, m_ready=0 -> exactly 2 rinc pulses, m_valid=1 with m_data=first word held stable. Release m_ready -> remaining 4 words out in order, no loss or duplicate.
- en=0 while rempty=0 with occ=1 -> rinc=0, buffered word delivered, then m_valid=0. en=1 -> pops resume next cycle.
- Sparse FIFO (one word every 3 cycles), 8 words, BURST_LEN=4 -> m_last on 4th and 8th accepted beats regardless of gaps.
- rrst_n=0 for one cycle with occ=2 -> m_valid=0, words_out=0, beat=0 on the next cycle; rinc=0 during the reset cycle. Following words restart framing at beat 0.
- CNT_W=4, 20 words streamed -> words_out saturates at 15 and stays 15.

Source files
------------

// File: rtl/afifo_rd_streamer_if.sv
// Read-side streamer bundle: FIFO pop interface plus the outgoing valid/ready stream.
// master is the streamer; slave is the FIFO/downstream environment around it.
interface afifo_rd_streamer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              en;
    logic              rempty;
    logic [DATA_W-1:0] rdata;
    logic              rinc;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic [CNT_W-1:0]  words_out;
    logic              busy;

    modport master (
        input  en, rempty, rdata, m_ready,
        output rinc, m_valid, m_data, m_last, words_out, busy
    );

    modport slave (
        output en, rempty, rdata, m_ready,
        input  rinc, m_valid, m_data, m_last, words_out, busy
    );
endinterface

// File: rtl/afifo_rd_streamer.sv
// Drains a first-word-fall-through async FIFO into a 2-entry buffer and re-presents
// the words on a valid/ready stream with burst framing and a saturating beat counter.
module afifo_rd_streamer #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                rclk,
    input  logic                rrst_n,
    afifo_rd_streamer_if.master bus
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [1:0]        occ_q, occ_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  words_out_q, words_out_d;
    logic              push;
    logic              pop;

    // Pop decision uses only registered occupancy, so m_ready never reaches rinc.
    always_comb begin
        push        = rrst_n & bus.en & ~bus.rempty & (occ_q != 2'd2);
        pop         = (occ_q != 2'd0) & bus.m_ready;
        occ_d       = occ_q;
        head_d      = head_q;
        tail_d      = tail_q;
        mem_d       = mem_q;
        beat_d      = beat_q;
        words_out_d = words_out_q;

        if (push) begin
            mem_d[tail_q] = bus.rdata;
            tail_d        = ~tail_q;
        end

        if (pop) begin
            head_d = ~head_q;
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
            if (words_out_q != '1) begin
                words_out_d = words_out_q + 1'b1;
            end
        end

        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            occ_q       <= '0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            beat_q      <= '0;
            words_out_q <= '0;
        end else begin
            occ_q       <= occ_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            mem_q       <= mem_d;
            beat_q      <= beat_d;
            words_out_q <= words_out_d;
        end
    end

    assign bus.rinc      = push;
    assign bus.m_valid   = (occ_q != 2'd0);
    assign bus.m_data    = mem_q[head_q];
    assign bus.m_last    = (occ_q != 2'd0) & (beat_q == LAST_BEAT);
    assign bus.words_out = words_out_q;
    assign bus.busy      = (occ_q != 2'd0) | push;
endmodule

// File: tb/tb_afifo_rd_streamer.sv
// Randomized and directed bench for afifo_rd_streamer; the FIFO and the 2-word
// buffer are modelled as queues, framing and counting as plain arithmetic.
module tb_afifo_rd_streamer;
    localparam int DATA_W = 8;
    localparam int BL     = 4;
    localparam int CW     = 4;

    logic rclk = 1'b0;
    logic rrst_n = 1'b0;

    always #5 rclk = ~rclk;

    afifo_rd_streamer_if #(.DATA_W(DATA_W), .CNT_W(CW)) bus_a ();
    afifo_rd_streamer_if #(.DATA_W(DATA_W), .CNT_W(16)) bus_b ();

    afifo_rd_streamer #(.DATA_W(DATA_W), .BURST_LEN(BL), .CNT_W(CW)) u_dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus_a.master)
    );

    afifo_rd_streamer #(.DATA_W(DATA_W), .BURST_LEN(1), .CNT_W(16)) u_dut1 (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus_b.master)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [DATA_W-1:0] fifo_q [$];
    logic [DATA_W-1:0] buf_q  [$];
    int unsigned beat        = 0;
    int unsigned cnt_a       = 0;
    int unsigned cnt_b       = 0;
    int unsigned rinc_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
    endtask

    // One read-clock cycle: drive at negedge, compare mid-cycle, update model at posedge.
    task automatic step(input logic rst_n_i, input logic en_i, input logic rdy_i, input bit chk);
        logic exp_rinc;
        logic exp_valid;
        logic xfer;
        @(negedge rclk);
        rrst_n        = rst_n_i;
        bus_a.en      = en_i;
        bus_b.en      = en_i;
        bus_a.m_ready = rdy_i;
        bus_b.m_ready = rdy_i;
        bus_a.rempty  = (fifo_q.size() == 0);
        bus_b.rempty  = (fifo_q.size() == 0);
        bus_a.rdata   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        bus_b.rdata   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        exp_rinc  = rst_n_i && en_i && (fifo_q.size() != 0) && (buf_q.size() < 2);
        exp_valid = (buf_q.size() != 0);
        if (chk) begin
            check("rinc", {31'd0, bus_a.rinc}, {31'd0, exp_rinc});
            check("rinc_b1", {31'd0, bus_b.rinc}, {31'd0, exp_rinc});
            check("m_valid", {31'd0, bus_a.m_valid}, {31'd0, exp_valid});
            check("m_valid_b1", {31'd0, bus_b.m_valid}, {31'd0, exp_valid});
            check("m_last", {31'd0, bus_a.m_last}, {31'd0, exp_valid && (beat == BL - 1)});
            check("m_last_b1", {31'd0, bus_b.m_last}, {31'd0, exp_valid});
            check("words_out", 32'(bus_a.words_out), cnt_a);
            check("words_out_b1", 32'(bus_b.words_out), cnt_b);
            check("busy", {31'd0, bus_a.busy}, {31'd0, exp_valid || exp_rinc});
            if (exp_valid) begin
                check("m_data", 32'(bus_a.m_data), 32'(buf_q[0]));
                check("m_data_b1", 32'(bus_b.m_data), 32'(buf_q[0]));
            end
        end
        xfer = exp_valid && rdy_i;
        if (exp_rinc) rinc_pulses++;
        @(posedge rclk);
        if (!rst_n_i) begin
            buf_q.delete();
            beat  = 0;
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (xfer) begin
                void'(buf_q.pop_front());
                beat = (beat + 1) % BL;
                if (cnt_a < (1 << CW) - 1) cnt_a++;
                if (cnt_b < 65535) cnt_b++;
            end
            if (exp_rinc) buf_q.push_back(fifo_q.pop_front());
        end
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("rst_m_data", 32'(bus_a.m_data), 32'd0);
        check("rst_m_valid", {31'd0, bus_a.m_valid}, 32'd0);

        // Preloaded burst of four at full throughput.
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        rinc_pulses = 0;
        repeat (7) step(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("burst_rinc_pulses", rinc_pulses, 32'd4);
        check("burst_words_out", 32'(bus_a.words_out), 32'd4);
        check("burst_busy_idle", {31'd0, bus_a.busy}, 32'd0);

        // Backpressure: only two pops while m_ready is low.
        for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i));
        rinc_pulses = 0;
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("bp_rinc_pulses", rinc_pulses, 32'd2);
        #1;
        check("bp_head_held", 32'(bus_a.m_data), 32'hA0);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b1);

        // en drop with one word buffered, then resume.
        for (int i = 0; i < 3; i++) push_word(8'hC0 + 8'(i));
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b1, 1'b1, 1'b1);

        // Sparse arrivals: framing must follow accepted beats, not FIFO gaps.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            push_word(8'h50 + 8'(i));
            repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
        end
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);

        // Reset while the buffer is full; unpopped words stay in the FIFO.
        for (int i = 0; i < 4; i++) push_word(8'h70 + 8'(i));
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        check("midrst_m_valid", {31'd0, bus_a.m_valid}, 32'd0);
        check("midrst_words_out", 32'(bus_a.words_out), 32'd0);
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b1);

        // Counter saturation on the narrow instance.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) push_word(8'(i * 7));
        repeat (25) step(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("sat_words_out", 32'(bus_a.words_out), 32'd15);
        check("sat_words_out_b1", 32'(bus_b.words_out), 32'd20);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (($urandom_range(0, 1) == 1) && (fifo_q.size() < 8)) push_word(8'($urandom));
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1),
                 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
